// File: rtl/hpdcache_regbank_arb_pkg.sv
// Shared definitions for the two-requester register-bank arbiter.
//   NREQ        : number of requesters sharing the bank
//   arb_state_e : controller state (power-on clear sweep / normal operation)
//   grant_t     : per-cycle arbitration decision (request side)
//   rsp_ctl_t   : per-requester read-response tracking (response side)
package hpdcache_regbank_arb_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic idx;
    logic we;
  } grant_t;

  typedef struct packed {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] rd_issued;
  } rsp_ctl_t;

endpackage

// File: rtl/hpdcache_regbank_wbyteenable_1rw.sv
// Single-port register bank with per-byte write enables.
//   clk   : clock, all storage updated on the rising edge
//   cs    : access enable
//   we    : 1 = write (bytes selected by wbe), 0 = read
//   addr  : entry index
//   wdata : write data
//   wbe   : byte enables, one per 8 data bits
//   rdata : read data, valid the cycle after a read access; holds otherwise
// Contents and read register are intentionally not reset.
module hpdcache_regbank_wbyteenable_1rw #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wbe,
  output logic [DATA_SIZE-1:0]   rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int b = 0; b < DATA_SIZE/8; b++) begin
          if (wbe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/hpdcache_regbank_arb.sv
// Two-requester round-robin front end for a shared single-port register bank.
// After reset the bank is swept to zero one entry per cycle; afterwards at most
// one request per cycle is granted and read data returns one cycle later on a
// per-requester valid/ready response channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake (ready is one-hot or zero)
//   req_we              : per-requester 1 = write, 0 = read
//   req_addr/wdata/wbe  : per-requester request fields, requester r in slice r
//   rsp_valid/rsp_ready : per-requester read-response handshake
//   rsp_rdata           : per-requester read data, requester r in slice r
//   init_done           : high once the power-on clear sweep has completed
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-write one bank entry per cycle, no requests accepted
// ST_RUN  | round-robin arbitration between requesters
module hpdcache_regbank_arb
  import hpdcache_regbank_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NREQ*DATA_SIZE-1:0]   req_wdata,
  input  logic [NREQ*DATA_SIZE/8-1:0] req_wbe,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [NREQ*DATA_SIZE-1:0]   rsp_rdata,
  output logic                        init_done
);

  localparam int unsigned          BE_SIZE   = DATA_SIZE/8;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  arb_state_e           state_q;
  logic [ADDR_SIZE-1:0] init_cnt_q;
  logic                 ptr_q;
  logic                 init_done_q;
  rsp_ctl_t             rsp_q;
  logic [DATA_SIZE-1:0] rdata_q [NREQ];

  logic [NREQ-1:0]      eligible;
  grant_t               gnt;
  logic [NREQ-1:0]      rd_gnt;

  logic [ADDR_SIZE-1:0] addr_s  [NREQ];
  logic [DATA_SIZE-1:0] wdata_s [NREQ];
  logic [BE_SIZE-1:0]   wbe_s   [NREQ];

  logic                 bank_cs;
  logic                 bank_we;
  logic [ADDR_SIZE-1:0] bank_addr;
  logic [DATA_SIZE-1:0] bank_wdata;
  logic [BE_SIZE-1:0]   bank_wbe;
  logic [DATA_SIZE-1:0] bank_rdata;

  // The bank read register only holds fresh data in the cycle right after the
  // read, so that cycle shows it directly and rdata_q keeps it from then on.
  for (genvar r = 0; r < NREQ; r++) begin : g_slice
    assign addr_s[r]  = req_addr[r*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_s[r] = req_wdata[r*DATA_SIZE +: DATA_SIZE];
    assign wbe_s[r]   = req_wbe[r*BE_SIZE +: BE_SIZE];
    assign rsp_rdata[r*DATA_SIZE +: DATA_SIZE] = rsp_q.rd_issued[r] ? bank_rdata : rdata_q[r];
  end

  assign rsp_valid = rsp_q.valid;
  assign init_done = init_done_q;

  // A requester whose read was granted last cycle sits out one cycle so its
  // response slot is never overwritten before it can be observed.
  always_comb begin
    eligible = req_valid & ~rsp_q.rd_issued & (~rsp_q.valid | rsp_ready);
    gnt      = '0;
    if (state_q == ST_RUN) begin
      if (eligible[ptr_q]) begin
        gnt.valid = 1'b1;
        gnt.idx   = ptr_q;
      end else if (eligible[~ptr_q]) begin
        gnt.valid = 1'b1;
        gnt.idx   = ~ptr_q;
      end
    end
    gnt.we    = gnt.valid & req_we[gnt.idx];
    req_ready = '0;
    if (gnt.valid) req_ready[gnt.idx] = 1'b1;
    rd_gnt    = req_ready & ~req_we;
  end

  always_comb begin
    bank_cs    = 1'b0;
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    bank_wbe   = '0;
    if (state_q == ST_INIT) begin
      bank_cs   = 1'b1;
      bank_we   = 1'b1;
      bank_addr = init_cnt_q;
      bank_wbe  = '1;
    end else if (gnt.valid) begin
      bank_cs    = 1'b1;
      bank_we    = gnt.we;
      bank_addr  = addr_s[gnt.idx];
      bank_wdata = wdata_s[gnt.idx];
      bank_wbe   = wbe_s[gnt.idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ptr_q       <= 1'b0;
      init_done_q <= 1'b0;
      rsp_q       <= '0;
      for (int r = 0; r < NREQ; r++) rdata_q[r] <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (gnt.valid) ptr_q <= ~gnt.idx;
        end
      endcase
      rsp_q.rd_issued <= rd_gnt;
      // A new response loading in the same cycle as a handshake wins.
      rsp_q.valid     <= rd_gnt | (rsp_q.valid & ~rsp_ready);
      for (int r = 0; r < NREQ; r++) begin
        if (rsp_q.rd_issued[r]) rdata_q[r] <= bank_rdata;
      end
    end
  end

  hpdcache_regbank_wbyteenable_1rw #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_regbank (
    .clk   (clk),
    .cs    (bank_cs),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .wbe   (bank_wbe),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_hpdcache_regbank_arb.sv
// Scoreboard bench for hpdcache_regbank_arb: a reference model (array memory,
// per-requester expected-response queues, preferred-requester index) predicts
// grants and read data; a monitor compares on every falling edge.
module tb_hpdcache_regbank_arb;

  localparam int A     = 4;
  localparam int D     = 64;
  localparam int DEPTH = 16;
  localparam int BE    = D/8;

  localparam int M_MANUAL = 0;
  localparam int M_CONT   = 1;
  localparam int M_RAND   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [2*A-1:0]  req_addr;
  logic [2*D-1:0]  req_wdata, rsp_rdata;
  logic [2*BE-1:0] req_wbe;
  logic            init_done;

  hpdcache_regbank_arb #(
    .ADDR_SIZE (A),
    .DATA_SIZE (D),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wbe   (req_wbe),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = M_MANUAL;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [D-1:0] mem_m [DEPTH];
  logic [D-1:0] q0[$];
  logic [D-1:0] q1[$];
  int           cyc;
  int           pref;
  int           ma;
  logic [1:0]   prev_rd, exp_v, elig, exp_gnt;
  logic [D-1:0] popv;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        q0.delete();
        q1.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        cyc     = 0;
        pref    = 0;
        prev_rd = '0;
      end else begin
        cyc++;
        exp_v   = {q1.size() != 0, q0.size() != 0};
        exp_gnt = '0;
        check("rsp_valid", rsp_valid, exp_v);
        if (cyc <= DEPTH) begin
          check("init_req_ready", req_ready, 2'b00);
          check("init_done_low", init_done, 1'b0);
        end else begin
          check("init_done_high", init_done, 1'b1);
          for (int r = 0; r < 2; r++)
            elig[r] = req_valid[r] && !prev_rd[r] && (!exp_v[r] || rsp_ready[r]);
          if (elig[pref])        exp_gnt[pref]   = 1'b1;
          else if (elig[1-pref]) exp_gnt[1-pref] = 1'b1;
          check("grant", req_ready, exp_gnt);
        end
        for (int r = 0; r < 2; r++) begin
          if (exp_v[r] && rsp_ready[r]) begin
            if (r == 0) popv = q0.pop_front();
            else        popv = q1.pop_front();
            check($sformatf("rsp_rdata_r%0d", r), rsp_rdata[r*D +: D], popv);
          end
        end
        prev_rd = '0;
        for (int r = 0; r < 2; r++) begin
          if (exp_gnt[r]) begin
            ma = int'(req_addr[r*A +: A]);
            if (req_we[r]) begin
              for (int b = 0; b < BE; b++)
                if (req_wbe[r*BE + b]) mem_m[ma][b*8 +: 8] = req_wdata[r*D + b*8 +: 8];
            end else begin
              if (r == 0) q0.push_back(mem_m[ma]);
              else        q1.push_back(mem_m[ma]);
              prev_rd[r] = 1'b1;
            end
            pref = 1 - r;
          end
        end
      end
    end
  end

  // ---------------- background request driver ----------------
  logic [1:0] drv_acc;

  initial begin
    forever begin
      @(negedge clk);
      drv_acc = req_ready;
      @(posedge clk);
      #1;
      if (mode == M_CONT || mode == M_RAND) begin
        for (int r = 0; r < 2; r++) begin
          if (drv_acc[r] || !req_valid[r]) begin
            if (mode == M_CONT) begin
              req_valid[r] = 1'b1;
              req_we[r]    = 1'b0;
              req_addr[r*A +: A] = A'($urandom_range(0, DEPTH-1));
            end else if ($urandom_range(0, 3) != 0) begin
              req_valid[r] = 1'b1;
              req_we[r]    = ($urandom_range(0, 2) == 0);
              req_addr[r*A +: A]    = A'($urandom_range(0, DEPTH-1));
              req_wdata[r*D +: D]   = {$urandom, $urandom};
              req_wbe[r*BE +: BE]   = BE'($urandom_range(0, 255));
            end else begin
              req_valid[r] = 1'b0;
            end
          end
          if (mode == M_CONT) rsp_ready[r] = 1'b1;
          else                rsp_ready[r] = ($urandom_range(0, 2) != 0);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int r, input logic v, input logic we, input logic [A-1:0] a,
                         input logic [D-1:0] wd, input logic [BE-1:0] be);
    req_valid[r]        = v;
    req_we[r]           = we;
    req_addr[r*A +: A]  = a;
    req_wdata[r*D +: D] = wd;
    req_wbe[r*BE +: BE] = be;
  endtask

  task automatic wait_accept(input int r, input int budget, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (req_ready[r]) done = 1'b1;
    end
    check($sformatf("accept_within_budget_r%0d", r), done, 1'b1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int n, k, first_c, last_c;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wbe   = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);

    // init sweep length, then continuous reads from both requesters
    set_req(0, 1'b1, 1'b0, A'(5), '0, '0);
    set_req(1, 1'b1, 1'b0, A'(9), '0, '0);
    mode = M_CONT;
    #2;
    rst_n = 1'b1;
    k = 0; first_c = 0; last_c = 0;
    for (int c = 1; c <= 80 && k < 8; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (k == 0) first_c = c;
        else check("rr_back_to_back", c, last_c + 1);
        check("rr_order", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        last_c = c;
        k++;
      end
    end
    check("first_grant_cycle", first_c, DEPTH + 1);
    check("rr_grant_count", k, 8);
    mode = M_MANUAL;
    @(posedge clk);
    #2;
    idle(4);

    // partial-byte write followed immediately by a read of the same entry
    set_req(0, 1'b1, 1'b1, A'(3), 64'h1122334455667788, 8'h0F);
    wait_accept(0, 10, n);
    set_req(0, 1'b1, 1'b0, A'(3), '0, '0);
    wait_accept(0, 10, n);
    check("raw_grant_latency", n, 1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("raw_rsp_valid", rsp_valid[0], 1'b1);
    check("raw_rdata", rsp_rdata[D-1:0], 64'h0000000055667788);
    @(posedge clk);
    #2;
    idle(3);

    // requester 1 back-pressures its response channel
    rsp_ready = 2'b01;
    set_req(1, 1'b1, 1'b1, A'(7), 64'hDEADBEEF_CAFEF00D, 8'hFF);
    wait_accept(1, 10, n);
    set_req(1, 1'b1, 1'b0, A'(7), '0, '0);
    wait_accept(1, 10, n);
    set_req(0, 1'b1, 1'b0, A'(3), '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid_r1", rsp_valid[1], 1'b1);
      check("hold_data_r1", rsp_rdata[2*D-1:D], 64'hDEADBEEFCAFEF00D);
      check("r1_blocked", req_ready[1], 1'b0);
      check("r0_every_eligible", req_ready[0], (i % 2 == 0));
    end
    @(posedge clk);
    #2;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("r1_grant_after_ready", req_ready, 2'b10);
    @(posedge clk);
    #2;
    idle(4);

    // randomized traffic against the model
    mode = M_RAND;
    repeat (1500) @(negedge clk);
    mode = M_MANUAL;
    @(posedge clk);
    #2;
    idle(5);

    // reset in the cycle after a read grant
    set_req(0, 1'b1, 1'b0, A'(3), '0, '0);
    wait_accept(0, 10, n);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_reset_rsp_valid", rsp_valid, 2'b00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("reinit_ready", req_ready, 2'b00);
      check("reinit_no_rsp", rsp_valid, 2'b00);
    end
    @(negedge clk);
    check("reinit_done", init_done, 1'b1);
    check("reinit_no_rsp_after", rsp_valid, 2'b00);
    @(posedge clk);
    #2;
    set_req(0, 1'b1, 1'b0, A'(3), '0, '0);
    wait_accept(0, 10, n);
    check("post_reset_grant_latency", n, 1);
    req_valid = 2'b00;
    @(negedge clk);
    check("post_reset_rsp_valid", rsp_valid[0], 1'b1);
    check("post_reset_rdata", rsp_rdata[D-1:0], 64'h0);
    @(posedge clk);
    #2;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_regbank_arb.md
HPDCACHE_REGBANK_ARB -- requirements
Module: hpdcache_regbank_arb

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, regbank address width.
REQ-002 SHALL have parameter DATA_SIZE, default 64, regbank data width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_SIZE, number of entries.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  2  per-requester request valid (bit r = requester r).
REQ-007 SHALL have port req_ready  output  2  per-requester request accepted.
REQ-008 SHALL have port req_we  input  2  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  2*ADDR_SIZE  requester r address in slice r.
REQ-010 SHALL have port req_wdata  input  2*DATA_SIZE  requester r write data in slice r.
REQ-011 SHALL have port req_wbe  input  2*DATA_SIZE/8  requester r byte enables in slice r.
REQ-012 SHALL have port rsp_valid  output  2  read data valid for requester r.
REQ-013 SHALL have port rsp_ready  input  2  requester r accepts read data.
REQ-014 SHALL have port rsp_rdata  output  2*DATA_SIZE  read data for requester r in slice r.
REQ-015 SHALL have port init_done  output  1  high once power-on clear has finished.

Function
REQ-016 SHALL be an FSM with states INIT and RUN; reset enters INIT.
REQ-017 In INIT: one full-width write of zero per cycle, address = counter 0..DEPTH-1; req_ready = 0.
REQ-018 On the cycle writing DEPTH-1: go to RUN, set init_done = 1 the following cycle; init_done stays high until reset.
REQ-019 In RUN, at most one request granted per cycle; req_ready is a one-hot or zero vector.
REQ-020 Requester r eligible iff req_valid[r]=1, no read of r issued the previous cycle, and rsp_valid[r]=0 or rsp_ready[r]=1.
REQ-021 Arbitration SHALL be round-robin: a one-bit pointer names the preferred requester; after any grant the pointer points to the other requester; no grant leaves pointer unchanged.
REQ-022 A grant drives the regbank in the same cycle: cs=1, we=req_we, addr/wdata/byte enables from the granted slice.
REQ-023 A read granted in cycle N SHALL set rsp_valid[r] and load rsp_rdata[r] in cycle N+1 (one-cycle latency).
REQ-024 rsp_valid[r] and rsp_rdata[r] SHALL hold until rsp_ready[r]=1 while rsp_valid[r]=1; the handshake clears rsp_valid[r] unless a new read response loads in the same cycle.
REQ-025 Writes SHALL produce no response; only bytes with wbe=1 are updated.
REQ-026 A read issued the cycle after a write to the same address SHALL return the written data.
REQ-027 req_valid with req_ready low SHALL have no effect; requesters keep request fields stable until accepted.
REQ-028 Idle cycle (no grant, not INIT): regbank cs=0.

Reset
REQ-029 While rst_n=0: state=INIT, init counter=0, pointer=0 (requester 0 preferred), req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
REQ-030 Reset mid-operation SHALL drop any in-flight read (no response after release) and restart INIT from address 0.
REQ-031 Regbank contents are not reset; the INIT sweep provides the zero state.

Structure
REQ-032 Shared package SHALL hold requester-count constant (2) and the request/response struct typedefs.
REQ-033 The storage SHALL be one instance of hpdcache_regbank_wbyteenable_1rw with matching ADDR_SIZE/DATA_SIZE/DEPTH; this block contains no storage array.

Verification
REQ-034 Reset release, DEPTH=16 -> req_ready=0 for 16 cycles, init_done=1 on cycle 17; read of addr 5 then returns 0.
REQ-035 Both requesters issue reads continuously, rsp_ready=1 -> grants alternate 0,1,0,1 (requester 0 first); each read of r is followed by one non-eligible cycle.
REQ-036 R0 writes addr 3 data 0x1122334455667788 wbe 0x0F, then reads addr 3 next cycle -> rsp_rdata[0]=0x0000000055667788.
REQ-037 R1 reads with rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and data held; R1 not granted; R0 granted every eligible cycle; after rsp_ready[1]=1, R1 granted next eligible cycle.
REQ-038 Assert rst_n=0 in the cycle after a read grant -> no rsp_valid after release; INIT restarts at address 0.
